// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit lookahead slice per clock,
// least-significant nibble first, with start/busy/done handshake and condition flags.
module nibble_serial_subtractor #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int            KW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // 4-bit carry-lookahead adder slice; returns {cout, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               last;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic               borrow_q;
  logic [KW-1:0]      k_q;

  logic [3:0]         a_nib;
  logic [3:0]         b_nib;
  logic [3:0]         sum_nib;
  logic               cout;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      RUN: begin
        if (k_q == K_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) accept = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) state_d = RUN;
  end

  // Subtraction as a + ~b + ~borrow; the slice's carry-out is the inverted borrow.
  always_comb begin
    a_nib = a_q[4*k_q +: 4];
    b_nib = b_q[4*k_q +: 4];
    {cout, sum_nib} = cla4(a_nib, ~b_nib, ~borrow_q);
    res_d = res_q;
    res_d[4*k_q +: 4] = sum_nib;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: operand, result and borrow registers are reset too, so no stale operand
  // survives a reset; the in-flight operation is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      borrow_q <= bin;
      k_q      <= '0;
    end else if (state_q == RUN) begin
      res_q    <= res_d;
      borrow_q <= ~cout;
      k_q      <= k_q + KW'(1);
      if (last) begin
        // Flags are taken from the completed result only, never from partial nibbles.
        diff <= res_d;
        bout <= ~cout;
        zero <= (res_d == '0);
        neg  <= res_d[WIDTH-1];
        ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench: a timeline/arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_nibble_serial_subtractor;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         neg;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nibble_serial_subtractor #(.NIBBLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic plus an operation timeline
  // (accepted op finishes N edges later; a new op is accepted only when none is pending).
  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         neg;
    logic         ovf;
  } res_t;

  function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
    res_t       r;
    logic [W:0] full;
    full   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    r.diff = full[W-1:0];
    r.bout = full[W];
    r.zero = (r.diff == '0);
    r.neg  = r.diff[W-1];
    r.ovf  = (x[W-1] != y[W-1]) && (r.diff[W-1] != x[W-1]);
    return r;
  endfunction

  res_t pending;
  res_t exp_r;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  int   remain   = 0;
  logic mdl_live = 1'b0;

  always @(posedge clk) begin
    mdl_live = 1'b1;
    if (reset) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      remain   = 0;
      exp_r    = '{default: '0};
    end else if (remain != 0) begin
      remain--;
      if (remain == 0) begin
        exp_busy = 1'b0;
        exp_done = 1'b1;
        exp_r    = pending;
      end
    end else if (start) begin
      pending  = ref_sub(a, b, bin);
      remain   = N;
      exp_busy = 1'b1;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mdl_live) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("diff", diff, exp_r.diff);
      check("bout", bout, exp_r.bout);
      check("zero", zero, exp_r.zero);
      check("neg",  neg,  exp_r.neg);
      check("ovf",  ovf,  exp_r.ovf);
      check("busy_done_excl", busy & done, 0);
    end
  end

  task automatic wait_done(input int max_cyc, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One isolated operation from IDLE with literal expectations, latency and busy length.
  task automatic do_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bi, input logic [W-1:0] e_diff, input logic e_bout,
                       input logic e_zero, input logic e_neg, input logic e_ovf);
    int   c0;
    int   busy_cnt;
    logic found;
    @(negedge clk);
    start = 1'b1; a = x; b = y; bin = bi;
    @(negedge clk);
    start = 1'b0;
    c0       = cyc;
    busy_cnt = 0;
    found    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, found, 1);
    check({name, "_latency"}, cyc - c0, N);
    check({name, "_busy_cycles"}, busy_cnt, N);
    check({name, "_diff"}, diff, e_diff);
    check({name, "_bout"}, bout, e_bout);
    check({name, "_zero"}, zero, e_zero);
    check({name, "_neg"},  neg,  e_neg);
    check({name, "_ovf"},  ovf,  e_ovf);
    @(negedge clk);
    check({name, "_done_fall"}, done, 0);
  endtask

  initial begin
    logic found;
    int   t1;
    int   t2;
    int   dcnt;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_flags", {bout, zero, neg, ovf}, 0);
    reset = 1'b0;

    do_op("xnib",  16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("ovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("bin",   16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Start while busy: the second request and the input changes must be ignored.
    @(negedge clk);
    start = 1'b1; a = 16'h5A5A; b = 16'h5A5A; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'h0000;
    @(negedge clk);
    start = 1'b0; a = 16'h1234; b = 16'h4321;
    wait_done(20, found);
    check("busy_start_done_seen", found, 1);
    check("busy_start_diff", diff, 16'h0000);
    check("busy_start_zero", zero, 1);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("busy_start_extra_done", dcnt, 0);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; a = 16'h0003; b = 16'h0001; bin = 1'b0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0003;
    wait_done(20, found);
    t1 = cyc;
    check("b2b_first_seen", found, 1);
    check("b2b_first_diff", diff, 16'h0002);
    check("b2b_first_bout", bout, 0);
    @(negedge clk);
    wait_done(20, found);
    t2 = cyc;
    start = 1'b0;
    check("b2b_second_seen", found, 1);
    check("b2b_period", t2 - t1, N + 1);
    check("b2b_second_diff", diff, 16'hFFFE);
    check("b2b_second_bout", bout, 1);
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h0001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_flags", {bout, zero, neg, ovf}, 0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    do_op("after_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
